data_mem_responder: RTL

- Responder end of the MEM-stage memory request interface.
- The MEM stage issues memRead/memWrite with the ALU address and store data; this block services the request from a word-addressed data RAM after a programmable latency.
- It returns load data, a completion pulse and an error flag.
- It drives a stall to hold the pipeline while a request is outstanding.

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// answers from a word-addressed RAM after LATENCY cycles, and stalls the pipeline meanwhile.
module data_mem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [31:0]   r_mem [DEPTH];
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_read;
  logic          r_write;
  logic          r_err;

  logic          w_req;
  logic [29:0]   w_word;
  logic          w_illegal;
  logic          w_accept;
  logic          w_commit;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;

  // Handshake: a request transfers on a rising edge where req_valid=1, at least one of
  // req_read/req_write is 1 and req_ready=1; the response is the single rsp_valid cycle.
  assign w_req     = req_valid && (req_read || req_write);
  assign w_word    = 30'((req_addr - ADDR_BASE) >> 2);
  assign w_illegal = (req_addr[1:0] != 2'b00) || (w_word >= 30'(DEPTH)) ||
                     (req_read && req_write);
  assign w_accept  = (r_state == S_IDLE) && w_req;

  // With LATENCY=1 the store commits on the accept edge, before the capture registers load.
  assign w_commit  = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_wr_en   = !reset && w_commit &&
                     ((r_state == S_IDLE) ? (req_write && !w_illegal) : (r_write && !r_err));
  assign w_wr_idx  = (r_state == S_IDLE) ? w_word[IW-1:0] : r_idx;
  assign w_wr_data = (r_state == S_IDLE) ? req_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_idx   <= w_word[IW-1:0];
        r_wdata <= req_wdata;
        r_read  <= req_read;
        r_write <= req_write;
        r_err   <= w_illegal;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_state == S_RESP) begin
        r_cnt <= 4'd0;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = w_req;
      end
      S_WAIT: stall = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (r_read && !r_err) rsp_rdata = r_mem[r_idx];
      end
      default: ;
    endcase
  end

endmodule
